// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB target.
//   sccb_state_t : protocol FSM states
//   BIT_TERM     : bits per byte (bit counter value at end of a byte)
//   CNT_SAT      : saturation value of the bit counter (byte + ACK slot)
//   SCCB_ACK/NA  : bus levels of the acknowledge / not-acknowledge slot
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_NA,
    ST_IGNORE
  } sccb_state_t;

  localparam logic [3:0] BIT_TERM = 4'd8;
  localparam logic [3:0] CNT_SAT  = 4'd9;
  localparam logic       SCCB_ACK = 1'b0;
  localparam logic       SCCB_NA  = 1'b1;

  function automatic logic [3:0] cnt_inc(input logic [3:0] cnt);
    return (cnt >= CNT_SAT) ? CNT_SAT : cnt + 4'd1;
  endfunction

  // Open-drain: a bus level of 0 means pull low, 1 means release.
  function automatic logic drives_low(input logic level);
    return (level == 1'b0);
  endfunction

endpackage

// File: rtl/sccb_edge_detect.sv
// sccb_edge_detect: brings sioc/siod into the xclk domain and flags bus events.
//   i_xclk, i_resetn : clock, async active-low reset
//   i_sioc, i_siod   : raw bus lines (asynchronous)
//   o_start/o_stop   : siod falling/rising while sioc high (one-cycle pulses)
//   o_rise/o_fall    : sioc edges (one-cycle pulses)
//   o_sda            : synchronized siod level, used for sampling on o_rise
module sccb_edge_detect
  import sccb_pkg::*;
(
  input  logic i_xclk,
  input  logic i_resetn,
  input  logic i_sioc,
  input  logic i_siod,
  output logic o_start,
  output logic o_stop,
  output logic o_rise,
  output logic o_fall,
  output logic o_sda
);

  // [0],[1] form the synchronizer, [2] is the history flop for edge detect.
  logic [2:0] r_scl_sync;
  logic [2:0] r_sda_sync;
  logic       w_scl;
  logic       w_scl_d;
  logic       w_sda_d;

  always_ff @(posedge i_xclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], i_sioc};
      r_sda_sync <= {r_sda_sync[1:0], i_siod};
    end
  end

  assign w_scl   = r_scl_sync[1];
  assign w_scl_d = r_scl_sync[2];
  assign o_sda   = r_sda_sync[1];
  assign w_sda_d = r_sda_sync[2];

  assign o_rise  =  w_scl & ~w_scl_d;
  assign o_fall  = ~w_scl &  w_scl_d;
  assign o_start =  w_scl &  w_sda_d & ~o_sda;
  assign o_stop  =  w_scl & ~w_sda_d &  o_sda;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB (3-wire subset, 2-wire bus) target bridging to a register file.
//   xclk, resetn       : clock, async active-low reset
//   sioc, siod         : SCCB clock in, open-drain data (drives 0 or z only)
//   reg_addr/reg_wdata : register pointer and write data
//   reg_we/reg_re      : one-cycle write / read strobes
//   reg_rdata          : read data, valid one xclk after reg_re
//   busy               : transaction in progress (START seen, no STOP yet)
//   nack_seen          : master acknowledged the final read byte (protocol error)
// Precondition: sioc high and low phases last at least 4 xclk cycles.
//
// state      | meaning
// IDLE       | bus idle, waiting for START
// ID         | shifting the device ID + R/W bit
// ID_ACK     | driving ACK for a matched ID
// SUB        | shifting the sub-address
// SUB_ACK    | driving ACK for the sub-address
// WDATA      | shifting write data (STOP here = 2-phase write)
// WDATA_ACK  | driving ACK for write data
// RDATA      | presenting read data, MSB first
// RD_NA      | siod released, master should leave the slot high
// IGNORE     | not addressed / transfer done, wait for START or STOP
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ID    = 8'h42,
  parameter int unsigned XCLK_FREQ = 10_000_000
) (
  input  logic       xclk,
  input  logic       resetn,
  input  logic       sioc,
  inout  wire        siod,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       nack_seen
);

  logic w_start, w_stop, w_rise, w_fall, w_sda;

  sccb_edge_detect u_edge (
    .i_xclk   (xclk),
    .i_resetn (resetn),
    .i_sioc   (sioc),
    .i_siod   (siod),
    .o_start  (w_start),
    .o_stop   (w_stop),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_sda    (w_sda)
  );

  sccb_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_tx, w_tx_nxt;
  logic        r_drv, w_drv_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_wdata, w_wdata_nxt;
  logic        r_we, w_we_nxt;
  logic        r_re, w_re_nxt;
  logic        r_re_d;
  logic        r_nack, w_nack_nxt;

  logic [7:0]  w_byte;
  logic        w_id_hit_now;
  logic        w_id_hit;

  // Byte as it stands including the bit being sampled on this RISE.
  assign w_byte       = {r_shift[6:0], w_sda};
  assign w_id_hit_now = (w_byte[7:1] == DEV_ID[7:1]);
  assign w_id_hit     = (r_shift[7:1] == DEV_ID[7:1]);

  always_ff @(posedge xclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_tx    <= '0;
      r_drv   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_re_d  <= 1'b0;
      r_nack  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_drv   <= w_drv_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_we    <= w_we_nxt;
      r_re    <= w_re_nxt;
      r_re_d  <= r_re;
      r_nack  <= w_nack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    // Register file answers one cycle after reg_re; grab the byte then.
    w_tx_nxt    = r_re_d ? reg_rdata : r_tx;
    w_drv_nxt   = r_drv;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_nack_nxt  = 1'b0;

    // START outranks everything (incl. a coincident RISE); covers repeated start.
    if (w_start) begin
      w_state_nxt = ST_ID;
      w_cnt_nxt   = '0;
      w_drv_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_drv_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_ID: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = cnt_inc(r_cnt);
            // Read strobe on the RISE that samples R/W, so data is ready
            // well before the first read bit goes out.
            if (r_cnt == BIT_TERM - 4'd1 && w_id_hit_now && w_sda)
              w_re_nxt = 1'b1;
          end else if (w_fall && r_cnt == BIT_TERM) begin
            if (w_id_hit) begin
              w_state_nxt = ST_ID_ACK;
              w_drv_nxt   = drives_low(SCCB_ACK);
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end
        end

        ST_SUB, ST_WDATA: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = cnt_inc(r_cnt);
            if (r_cnt == BIT_TERM - 4'd1) begin
              if (r_state == ST_SUB) begin
                w_addr_nxt = w_byte;
              end else begin
                w_wdata_nxt = w_byte;
                w_we_nxt    = 1'b1;
              end
            end
          end else if (w_fall && r_cnt == BIT_TERM) begin
            w_state_nxt = (r_state == ST_SUB) ? ST_SUB_ACK : ST_WDATA_ACK;
            w_drv_nxt   = drives_low(SCCB_ACK);
          end
        end

        // ACK held from the 8th FALL to the 9th FALL; the 9th RISE
        // saturates the counter, marking the end of the slot.
        ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          if (w_rise) begin
            w_cnt_nxt = cnt_inc(r_cnt);
          end else if (w_fall && r_cnt == CNT_SAT) begin
            w_cnt_nxt = '0;
            w_drv_nxt = 1'b0;
            if (r_state == ST_ID_ACK) begin
              if (r_shift[0]) begin
                w_state_nxt = ST_RDATA;
                w_drv_nxt   = drives_low(r_tx[7]);
              end else begin
                w_state_nxt = ST_SUB;
              end
            end else if (r_state == ST_SUB_ACK) begin
              w_state_nxt = ST_WDATA;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end
        end

        ST_RDATA: begin
          if (w_rise) begin
            w_cnt_nxt = cnt_inc(r_cnt);
          end else if (w_fall && r_cnt == BIT_TERM) begin
            w_state_nxt = ST_RD_NA;
            w_drv_nxt   = drives_low(SCCB_NA);
          end else if (w_fall && r_cnt != 4'd0) begin
            w_tx_nxt  = {r_tx[6:0], 1'b0};
            w_drv_nxt = drives_low(r_tx[6]);
          end
        end

        ST_RD_NA: begin
          if (w_rise) begin
            w_nack_nxt  = (w_sda == SCCB_ACK);
            w_state_nxt = ST_IGNORE;
          end
        end

        ST_IDLE, ST_IGNORE: w_drv_nxt = 1'b0;

        default: begin
          w_state_nxt = ST_IDLE;
          w_drv_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign siod      = r_drv ? 1'b0 : 1'bz;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = (r_state != ST_IDLE);
  assign nack_seen = r_nack;

  // SCCB tops out at 100 kHz; 4-cycle phases need at least 800 kHz xclk.
  a_xclk_fast_enough : assert property (@(posedge xclk) XCLK_FREQ >= 32'd800_000);
  a_no_we_re_overlap : assert property (@(posedge xclk) disable iff (!resetn) !(r_we && r_re));

endmodule

// File: tb/tb_sccb_target.sv
`timescale 1ns/1ps
module tb_sccb_target;

  localparam int         Q     = 5;
  localparam int         H     = 10;
  localparam logic [7:0] WR_ID = 8'h42;
  localparam logic [7:0] RD_ID = 8'h43;

  logic       xclk = 1'b0;
  logic       resetn = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        siod;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, nack_seen;

  pullup pu_siod (siod);
  assign siod = m_sda_low ? 1'b0 : 1'bz;

  sccb_target #(.DEV_ID(8'h42), .XCLK_FREQ(100_000_000)) dut (
    .xclk      (xclk),
    .resetn    (resetn),
    .sioc      (m_scl),
    .siod      (siod),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  always #5 xclk = ~xclk;

  // External register file: write on strobe, read data one cycle after reg_re.
  logic [7:0] rf_mem [256] = '{default: 8'h00};
  always @(posedge xclk) begin
    if (reg_we) rf_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= rf_mem[reg_addr];
  end

  int         n_we = 0, n_re = 0, n_nack = 0;
  logic [7:0] last_wdata = 8'h00;
  always @(negedge xclk) begin
    if (reg_we) begin n_we++; last_wdata = reg_wdata; end
    if (reg_re) n_re++;
    if (nack_seen) n_nack++;
  end

  // Reference model: register contents and pointer as a master would see them.
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_cyc(Q);
    m_scl = 1'b1;     wait_cyc(H);
    m_sda_low = 1'b1; wait_cyc(H);
    m_scl = 1'b0;     wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_cyc(Q);
    m_scl = 1'b1;     wait_cyc(H);
    m_sda_low = 1'b0; wait_cyc(H);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wait_cyc(Q);
    m_scl = 1'b1;   wait_cyc(H);
    m_scl = 1'b0;   wait_cyc(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; wait_cyc(Q);
    m_scl = 1'b1;     wait_cyc(H / 2);
    b = siod;         wait_cyc(H - H / 2);
    m_scl = 1'b0;     wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_lvl);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_lvl);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d, output logic na_lvl);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin recv_bit(b); d = {d[6:0], b}; end
    m_sda_low = master_ack; wait_cyc(Q);
    m_scl = 1'b1;           wait_cyc(H / 2);
    na_lvl = siod;          wait_cyc(H - H / 2);
    m_scl = 1'b0;           wait_cyc(Q);
    m_sda_low = 1'b0;
  endtask

  task automatic txn_write3(input logic [7:0] addr, input logic [7:0] data, input logic extra);
    logic a0, a1, a2, a3;
    int   we0;
    we0 = n_we;
    bus_start();
    check("w3_busy", 32'(busy), 1);
    write_byte(WR_ID, a0);
    write_byte(addr, a1);
    write_byte(data, a2);
    check("w3_ack_id", 32'(a0), 0);
    check("w3_ack_sub", 32'(a1), 0);
    check("w3_ack_data", 32'(a2), 0);
    if (extra) begin
      write_byte(8'($urandom), a3);
      check("w3_extra_nack", 32'(a3), 1);
    end
    bus_stop();
    m_mem[addr] = data;
    m_ptr = addr;
    check("w3_addr", 32'(reg_addr), 32'(m_ptr));
    check("w3_we_cnt", n_we - we0, 1);
    check("w3_wdata", 32'(last_wdata), 32'(data));
    check("w3_mem", 32'(rf_mem[addr]), 32'(m_mem[addr]));
    check("w3_idle", 32'(busy), 0);
  endtask

  task automatic txn_write2(input logic [7:0] addr);
    logic a0, a1;
    int   we0;
    we0 = n_we;
    bus_start();
    write_byte(WR_ID, a0);
    write_byte(addr, a1);
    bus_stop();
    m_ptr = addr;
    check("w2_ack_id", 32'(a0), 0);
    check("w2_ack_sub", 32'(a1), 0);
    check("w2_addr", 32'(reg_addr), 32'(m_ptr));
    check("w2_no_we", n_we - we0, 0);
    check("w2_idle", 32'(busy), 0);
  endtask

  task automatic txn_read(input logic master_ack);
    logic       a0, na;
    logic [7:0] d;
    int         re0, nk0;
    re0 = n_re; nk0 = n_nack;
    bus_start();
    write_byte(RD_ID, a0);
    read_byte(master_ack, d, na);
    bus_stop();
    check("rd_ack_id", 32'(a0), 0);
    check("rd_data", 32'(d), 32'(m_mem[m_ptr]));
    check("rd_re_cnt", n_re - re0, 1);
    check("rd_nack_cnt", n_nack - nk0, master_ack ? 1 : 0);
    if (!master_ack) check("rd_na_released", 32'(na), 1);
    check("rd_addr", 32'(reg_addr), 32'(m_ptr));
    check("rd_idle", 32'(busy), 0);
  endtask

  task automatic txn_combined(input logic [7:0] addr);
    logic       a0, a1, a2, na;
    logic [7:0] d;
    int         re0;
    re0 = n_re;
    bus_start();
    write_byte(WR_ID, a0);
    write_byte(addr, a1);
    bus_start();
    write_byte(RD_ID, a2);
    read_byte(1'b0, d, na);
    bus_stop();
    m_ptr = addr;
    check("cmb_acks", {29'd0, a0, a1, a2}, 0);
    check("cmb_data", 32'(d), 32'(m_mem[addr]));
    check("cmb_re_cnt", n_re - re0, 1);
    check("cmb_na_released", 32'(na), 1);
  endtask

  task automatic txn_wrong(input logic [7:0] id, input int nbytes);
    logic a;
    int   we0, re0;
    we0 = n_we; re0 = n_re;
    bus_start();
    write_byte(id, a);
    check("wid_nack_id", 32'(a), 1);
    for (int i = 0; i < nbytes; i++) begin
      write_byte(8'($urandom), a);
      check("wid_nack_payload", 32'(a), 1);
    end
    check("wid_busy", 32'(busy), 1);
    bus_stop();
    check("wid_no_we", n_we - we0, 0);
    check("wid_no_re", n_re - re0, 0);
    check("wid_idle", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, b;
    logic [7:0] v, id;
    logic [2:0] got3;

    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_ptr = 8'h00;

    // Reset values
    wait_cyc(3);
    check("rst_addr", 32'(reg_addr), 0);
    check("rst_wdata", 32'(reg_wdata), 0);
    check("rst_we", 32'(reg_we), 0);
    check("rst_re", 32'(reg_re), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_nack", 32'(nack_seen), 0);
    check("rst_siod", 32'(siod), 1);
    resetn = 1'b1;
    wait_cyc(5);

    // 3-phase write
    txn_write3(8'h12, 8'h80, 1'b0);

    // 2-phase write then 2-phase read of 0xA5
    txn_write3(8'h0A, 8'hA5, 1'b0);
    txn_write2(8'h0A);
    txn_read(1'b0);

    // Wrong device ID
    txn_wrong(8'h60, 2);

    // Abort after 4 bits of sub-address 0x3C
    bus_start();
    write_byte(WR_ID, a);
    check("abort_ack_id", 32'(a), 0);
    v = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(v[i]);
    bus_stop();
    check("abort_addr", 32'(reg_addr), 32'(m_ptr));
    check("abort_idle", 32'(busy), 0);
    txn_write3(8'h3C, 8'h11, 1'b0);

    // Reset while the target is driving a 0 in bit 4 of read data
    v = 8'($urandom) & 8'hEF;
    txn_write3(8'h00, v, 1'b0);
    bus_start();
    write_byte(RD_ID, a);
    got3 = 3'b000;
    for (int i = 0; i < 3; i++) begin recv_bit(b); got3 = {got3[1:0], b}; end
    check("rstrd_bits", 32'(got3), 32'(v[7:5]));
    check("rstrd_driving", 32'(siod), 0);
    resetn = 1'b0;
    #1;
    check("rstrd_siod", 32'(siod), 1);
    check("rstrd_outs", {26'd0, reg_we, reg_re, busy, nack_seen, reg_addr != 8'h00, reg_wdata != 8'h00}, 0);
    m_ptr = 8'h00;
    wait_cyc(4);
    resetn = 1'b1;
    wait_cyc(6);
    txn_read(1'b0);

    // Master acknowledges the NA slot
    txn_read(1'b1);

    // Randomized traffic over a small address pool
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 4))
        0: txn_write3(8'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        1: txn_write2(8'($urandom_range(0, 7)));
        2: txn_read(1'($urandom_range(0, 3) == 0));
        3: begin
          do id = 8'($urandom); while (id[7:1] == WR_ID[7:1]);
          txn_wrong(id, $urandom_range(0, 2));
        end
        default: txn_combined(8'($urandom_range(0, 7)));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 Parameter DEV_ID, default 8'h42, 8-bit device address; bits [7:1] are matched against the ID byte and bit 0 is ignored.
REQ-002 Parameter XCLK_FREQ, default 10_000_000, xclk frequency in Hz, used only for documentation and assertion bounds.
REQ-003 Port xclk, input, 1, single clock; every flop SHALL be clocked by xclk.
REQ-004 Port resetn, input, 1, reset; asynchronous, active-low.
REQ-005 Port sioc, input, 1, SCCB clock from the master; asynchronous to xclk.
REQ-006 Port siod, inout, 1, SCCB data; this block SHALL only drive 0 or release to z (open-drain).
REQ-007 Port reg_addr, output, 8, register pointer presented to the external register file.
REQ-008 Port reg_wdata, output, 8, write data.
REQ-009 Port reg_we, output, 1, one-cycle write strobe.
REQ-010 Port reg_re, output, 1, one-cycle read strobe.
REQ-011 Port reg_rdata, input, 8, read data; valid exactly 1 xclk after reg_re.
REQ-012 Port busy, output, 1, high from a detected START until a STOP or a return to IDLE.
REQ-013 Port nack_seen, output, 1, one-cycle pulse when the master drives 0 (ACK) in the NA slot of a read, which is a protocol error.

Function
REQ-014 sioc and siod-in SHALL each pass through a 2-FF synchronizer and a third history flop; all edge detection SHALL use the synchronized values.
REQ-015 Edge detection SHALL define four events: START = siod falling while sioc is high; STOP = siod rising while sioc is high; RISE = sioc rising; FALL = sioc falling.
REQ-016 Data SHALL be sampled on RISE, and siod drive changes SHALL occur on FALL, 1 xclk after the event is detected.
REQ-017 The FSM states SHALL be IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA and IGNORE.
REQ-018 START in any state SHALL go to ID with the bit count cleared; this covers the repeated start.
REQ-019 STOP in any state SHALL go to IDLE, release siod and clear busy.
REQ-020 ID SHALL shift 8 bits MSB first; on the 8th FALL the next state is decided as follows:
  - ID[7:1]==DEV_ID[7:1] -> go to ID_ACK.
  - Otherwise -> go to IGNORE and never drive siod.
REQ-021 During every ACK state (ID_ACK, SUB_ACK, WDATA_ACK), siod SHALL be driven 0 from the 8th FALL to the 9th FALL, then released.
REQ-022 From ID_ACK the next state SHALL be SUB when R/W=0, or RDATA when R/W=1.
REQ-023 When R/W=1, reg_re SHALL pulse on the RISE that samples the R/W bit.
REQ-024 SUB SHALL shift 8 bits; on the 8th RISE, reg_addr SHALL load the byte; the FSM then goes to SUB_ACK, then WDATA.
REQ-025 In WDATA, a STOP before the first RISE ends a 2-phase write: pointer updated, no reg_we.
REQ-026 In WDATA, on the 8th RISE, reg_wdata SHALL load the byte and reg_we SHALL pulse for 1 cycle; the FSM then goes to WDATA_ACK.
REQ-027 After WDATA_ACK the FSM SHALL go to IGNORE; further bytes are not acknowledged and reg_addr does not auto-increment.
REQ-028 On entry to RDATA, reg_rdata SHALL be captured into a shift register at the reg_re+1 cycle.
REQ-029 In RDATA, each FALL (starting with the ID_ACK 9th FALL) SHALL present the next bit, MSB first: drive 0 for a 0 bit, release for a 1 bit.
REQ-030 After the 8th data bit, siod SHALL be released for RD_NA; siod sampled 0 on that RISE pulses nack_seen; in both cases the FSM goes to IGNORE.
REQ-031 The bit counter SHALL be 4 bits wide and saturate at 9; it never wraps.
REQ-032 RISE and START detected in the same cycle SHALL give START priority.
REQ-033 sioc high-time and low-time SHALL each be at least 4 xclk cycles; this is a documented precondition, not checked in RTL.

Reset
REQ-034 resetn low SHALL asynchronously force the following values, including mid-transfer:
  - state to IDLE, with siod released;
  - busy, reg_we, reg_re and nack_seen to 0;
  - reg_addr and reg_wdata to 0;
  - synchronizer flops to 1.
REQ-035 After reset is released, the FSM SHALL ignore the bus until a fresh START.

Structure
REQ-036 A shared package sccb_pkg SHALL hold the FSM state enum, the bit-count terminal value (8) and the ACK/NA constants.
REQ-037 One sub-module, sccb_edge_detect, SHALL contain the synchronizers plus the START/STOP/RISE/FALL generation; sccb_target instantiates it once.

Verification
REQ-038 3-phase write: ID 0x42, sub 0x12, data 0x80, STOP -> three ACK slots driven 0, reg_addr=0x12, reg_we pulses once with reg_wdata=0x80.
REQ-039 2-phase write then 2-phase read: ID 0x42 and sub 0x0A, STOP, START, ID 0x43; reg_rdata=0xA5 -> reg_re pulses once, siod carries 1010_0101 and is released in the NA slot.
REQ-040 Wrong ID: ID 0x60 with any payload -> siod never driven, reg_we and reg_re stay 0, busy drops at STOP.
REQ-041 Abort: STOP after the 4th bit of sub 0x3C -> FSM in IDLE, reg_addr unchanged; the next 3-phase write to 0x3C with data 0x11 succeeds.
REQ-042 Reset during RDATA bit 3 -> siod z within 0 cycles of the resetn assertion, all outputs 0; the following ID 0x43 read returns the correct byte.
REQ-043 Master ACKs the NA slot on read 0x43 -> nack_seen pulses 1 cycle, siod released, FSM returns to IDLE at STOP.
